// File: rtl/ln_result_collector.sv
// LayerNorm stage-4 result collector.
// Captures tagged result beats (any order) into a ping-pong frame buffer and,
// once a frame's 64 tags are all present, streams it out in ascending tag
// order on a valid/ready interface. One buffer fills while the other drains.
module ln_result_collector #(
  parameter int DATA_W = 1024,
  parameter int ADDR_W = 6,
  parameter int NBUF   = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_res_valid,
  input  logic [ADDR_W-1:0] i_res_addr,
  input  logic [DATA_W-1:0] i_res_data_flat,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last,
  output logic              o_frame_done,
  output logic              o_overflow,
  output logic              o_dup_err,
  input  logic              i_clear_err
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {S_IDLE, S_STREAM} state_e;

  // Frame storage: buffer select is the top address bit, tag the rest.
  logic [DATA_W-1:0] mem_q [NBUF*DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  logic [DEPTH-1:0]  bitmap_q [NBUF];
  logic [NBUF-1:0]   full_q;
  logic              w_sel_q;
  logic              r_sel_q;
  logic              overflow_q;
  logic              dup_err_q;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   fetch_q;       // next tag to fetch; MSB set once all fetched
  logic              rd_vld_q;      // prefetch stage (memory read register) holds a beat
  logic [ADDR_W-1:0] rd_addr_q;

  logic              o_valid_q;
  logic [DATA_W-1:0] o_data_q;
  logic [ADDR_W-1:0] o_addr_q;
  logic              o_last_q;
  logic              frame_done_q;

  // Write-side decode
  logic [DEPTH-1:0]  tag_onehot;
  logic              wr_hit, wr_dup, wr_complete, wr_drop;

  // Read-side handshake decode
  logic              out_free, out_fire, frame_end, rd_free;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;

  assign tag_onehot  = DEPTH'(1) << i_res_addr;
  assign wr_hit      = i_res_valid && !full_q[w_sel_q];
  assign wr_drop     = i_res_valid &&  full_q[w_sel_q];
  assign wr_dup      = wr_hit && bitmap_q[w_sel_q][i_res_addr];
  assign wr_complete = wr_hit && ((bitmap_q[w_sel_q] | tag_onehot) == '1);

  // The output register is free when empty or being consumed this cycle.
  assign out_free  = !o_valid_q || i_ready;
  assign out_fire  = o_valid_q && i_ready;
  assign frame_end = out_fire && o_last_q;
  assign rd_free   = !rd_vld_q || out_free;

  // Block RAM: one write port (fill side) and one registered read port (drain side).
  always_ff @(posedge i_clk) begin
    if (wr_hit) begin
      mem_q[{w_sel_q, i_res_addr}] <= i_res_data_flat;
    end
    if (issue) begin
      rd_data_q <= mem_q[{r_sel_q, issue_addr}];
    end
  end

  // Fill bookkeeping: received bitmaps, full flags and the ping-pong selectors.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < NBUF; b++) bitmap_q[b] <= '0;
      full_q  <= '0;
      w_sel_q <= 1'b0;
      r_sel_q <= 1'b0;
    end else begin
      if (wr_complete) begin
        bitmap_q[w_sel_q] <= '0;
        full_q[w_sel_q]   <= 1'b1;
        w_sel_q           <= ~w_sel_q;
      end else if (wr_hit) begin
        bitmap_q[w_sel_q] <= bitmap_q[w_sel_q] | tag_onehot;
      end
      // Set and clear never hit the same buffer: set needs it empty, clear needs it full.
      if (frame_end) begin
        full_q[r_sel_q] <= 1'b0;
        r_sel_q         <= ~r_sel_q;
      end
    end
  end

  // Sticky error flags; a new event in the same cycle beats the clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overflow_q <= 1'b0;
      dup_err_q  <= 1'b0;
    end else begin
      if (wr_drop)          overflow_q <= 1'b1;
      else if (i_clear_err) overflow_q <= 1'b0;
      if (wr_dup)           dup_err_q  <= 1'b1;
      else if (i_clear_err) dup_err_q  <= 1'b0;
    end
  end

  // Read FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Read FSM next-state: start on a full buffer, return after the last handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (full_q[r_sel_q]) state_d = S_STREAM;
      S_STREAM: if (frame_end)       state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Read FSM outputs: when to issue a memory read and for which tag.
  always_comb begin
    issue      = 1'b0;
    issue_addr = fetch_q[ADDR_W-1:0];
    case (state_q)
      S_IDLE: begin
        issue_addr = '0;
        issue      = full_q[r_sel_q];
      end
      S_STREAM: issue = !fetch_q[ADDR_W] && rd_free;
      default: issue = 1'b0;
    endcase
  end

  // Fetch counter plus prefetch-stage valid/tag (the one-entry skid).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_q   <= '0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      if (issue) begin
        fetch_q   <= (state_q == S_IDLE) ? (ADDR_W+1)'(1) : fetch_q + (ADDR_W+1)'(1);
        rd_vld_q  <= 1'b1;
        rd_addr_q <= issue_addr;
      end else if (out_free) begin
        rd_vld_q  <= 1'b0;
      end
    end
  end

  // Output register: loads from the prefetch stage whenever it is free, holds on stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid_q    <= 1'b0;
      o_data_q     <= '0;
      o_addr_q     <= '0;
      o_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_end;
      if (out_free) begin
        o_valid_q <= rd_vld_q;
        if (rd_vld_q) begin
          o_data_q <= rd_data_q;
          o_addr_q <= rd_addr_q;
          o_last_q <= (rd_addr_q == ADDR_W'(DEPTH-1));
        end
      end
    end
  end

  assign o_valid      = o_valid_q;
  assign o_data       = o_data_q;
  assign o_addr       = o_addr_q;
  assign o_last       = o_last_q;
  assign o_frame_done = frame_done_q;
  assign o_overflow   = overflow_q;
  assign o_dup_err    = dup_err_q;

endmodule

// File: tb/tb_ln_result_collector.sv
// Scoreboard testbench for ln_result_collector: stimulus pushes expected
// beats, an independent monitor pops and compares on every handshake.
module tb_ln_result_collector;

  logic          clk;
  logic          rst_n;
  logic          res_valid;
  logic [5:0]    res_addr;
  logic [1023:0] res_data;
  logic          o_valid;
  logic          i_ready;
  logic [1023:0] o_data;
  logic [5:0]    o_addr;
  logic          o_last;
  logic          o_frame_done;
  logic          o_overflow;
  logic          o_dup_err;
  logic          clear_err;

  typedef struct {
    logic [5:0]    addr;
    logic [1023:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ln_result_collector dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_res_valid    (res_valid),
    .i_res_addr     (res_addr),
    .i_res_data_flat(res_data),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_data         (o_data),
    .o_addr         (o_addr),
    .o_last         (o_last),
    .o_frame_done   (o_frame_done),
    .o_overflow     (o_overflow),
    .o_dup_err      (o_dup_err),
    .i_clear_err    (clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Payload pattern: seed 0 = tag replicated in every lane, otherwise {seed, lane, tag}.
  function automatic logic [1023:0] pat(input int seed, input int tag);
    logic [1023:0] r;
    logic [5:0] k6, t6;
    logic [3:0] s4;
    t6 = tag[5:0];
    s4 = seed[3:0];
    for (int k = 0; k < 64; k++) begin
      k6 = k[5:0];
      if (seed == 0) r[16*k +: 16] = {10'd0, t6};
      else           r[16*k +: 16] = {s4, k6, t6};
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic wr(input int tag, input logic [1023:0] d);
    res_valid = 1'b1;
    res_addr  = tag[5:0];
    res_data  = d;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic push(input int tag, input logic [1023:0] d);
    exp_t e;
    e.addr = tag[5:0];
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wr_frame(input int seed);
    for (int t = 0; t < 64; t++) wr(t, pat(seed, t));
  endtask

  task automatic push_frame(input int seed);
    for (int t = 0; t < 64; t++) push(t, pat(seed, t));
  endtask

  // Wait for n frame_done pulses; bp selects the 1,0,0,1 ready pattern.
  task automatic drain(input int nframes, input int budget, input bit bp, input string nm);
    int got;
    got = 0;
    for (int c = 0; c < budget && got < nframes; c++) begin
      if (bp) i_ready = ((c % 4) == 0) || ((c % 4) == 3);
      tick();
      if (o_frame_done) got++;
    end
    i_ready = 1'b1;
    chk({nm, "_frames_done"}, 64'(got), 64'(nframes));
    chk({nm, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compares each accepted beat against the scoreboard and checks
  // that a stalled beat holds steady until accepted.
  initial begin
    exp_t       e;
    bit         stall_prev;
    logic [5:0] h_addr;
    logic [1023:0] h_data;
    logic       h_last;
    stall_prev = 1'b0;
    h_addr = '0; h_data = '0; h_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
        continue;
      end
      if (stall_prev) begin
        n_checks++;
        if (!(o_valid && o_addr == h_addr && o_data == h_data && o_last == h_last)) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%0b tag=%0d last=%0b, expected valid=1 tag=%0d last=%0b",
                   o_valid, o_addr, o_last, h_addr, h_last);
        end
      end
      if (o_valid && i_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got tag %0d, expected no beat", o_addr);
        end else begin
          e = exp_q.pop_front();
          if (o_addr !== e.addr || o_data !== e.data || o_last !== (e.addr == 6'd63)) begin
            n_fail++;
            $display("FAIL beat: got tag %0d last %0b data[63:0] %h, expected tag %0d last %0b data[63:0] %h",
                     o_addr, o_last, o_data[63:0], e.addr, (e.addr == 6'd63), e.data[63:0]);
          end
        end
      end
      stall_prev = o_valid && !i_ready;
      h_addr = o_addr;
      h_data = o_data;
      h_last = o_last;
    end
  end

  initial begin
    int  k;
    bit  found;
    rst_n     = 1'b0;
    res_valid = 1'b0;
    res_addr  = '0;
    res_data  = '0;
    i_ready   = 1'b1;
    clear_err = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_valid",    64'(o_valid), 64'd0);
    chk("rst_last",     64'(o_last), 64'd0);
    chk("rst_done",     64'(o_frame_done), 64'd0);
    chk("rst_overflow", 64'(o_overflow), 64'd0);
    chk("rst_dup",      64'(o_dup_err), 64'd0);
    chk("rst_addr",     64'(o_addr), 64'd0);

    // In-order frame with latency and no-bubble checks
    wr_frame(0);
    push_frame(0);
    chk("lat_edge0_valid", 64'(o_valid), 64'd0);
    tick();
    chk("lat_edge1_valid", 64'(o_valid), 64'd0);
    tick();
    chk("lat_edge2_valid", 64'(o_valid), 64'd1);
    chk("lat_edge2_addr",  64'(o_addr), 64'd0);
    k = 0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (o_frame_done) begin
        k = c;
        break;
      end
    end
    chk("inorder_drain_cycles", 64'(k), 64'd64);
    tick();
    chk("inorder_done_single_pulse", 64'(o_frame_done), 64'd0);
    chk("inorder_queue_empty", 64'(exp_q.size()), 64'd0);

    // Scrambled arrival: bank 3..0, cycle 15..0
    for (int b = 3; b >= 0; b--)
      for (int cy = 15; cy >= 0; cy--)
        wr(b*16 + cy, pat(1, b*16 + cy));
    push_frame(1);
    drain(1, 200, 1'b0, "scrambled");
    chk("scrambled_overflow", 64'(o_overflow), 64'd0);
    chk("scrambled_dup",      64'(o_dup_err), 64'd0);

    // Backpressure drain with ready pattern 1,0,0,1
    wr_frame(2);
    push_frame(2);
    drain(1, 600, 1'b1, "backpressure");

    // Ping-pong overflow: both buffers full, one extra beat dropped
    i_ready = 1'b0;
    wr_frame(3);
    push_frame(3);
    wr_frame(4);
    push_frame(4);
    chk("ovf_before_extra", 64'(o_overflow), 64'd0);
    wr(7, pat(5, 7));
    chk("ovf_set", 64'(o_overflow), 64'd1);
    repeat (3) tick();
    i_ready = 1'b1;
    drain(2, 400, 1'b0, "overflow");
    chk("ovf_sticky", 64'(o_overflow), 64'd1);
    chk("ovf_no_dup", 64'(o_dup_err), 64'd0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("ovf_cleared", 64'(o_overflow), 64'd0);

    // Duplicate tag 5: second payload wins
    wr(5, {64{16'hAAAA}});
    chk("dup_first_write", 64'(o_dup_err), 64'd0);
    wr(5, {64{16'hBBBB}});
    chk("dup_set", 64'(o_dup_err), 64'd1);
    for (int t = 0; t < 64; t++) if (t != 5) wr(t, pat(6, t));
    for (int t = 0; t < 64; t++) push(t, (t == 5) ? {64{16'hBBBB}} : pat(6, t));
    drain(1, 200, 1'b0, "dup");
    chk("dup_sticky", 64'(o_dup_err), 64'd1);
    chk("dup_no_overflow", 64'(o_overflow), 64'd0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("dup_cleared", 64'(o_dup_err), 64'd0);

    // Reset in the middle of a drain at tag 20
    wr_frame(7);
    push_frame(7);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (o_valid && o_addr == 6'd20) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("midrst_reached_tag20", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_addr",  64'(o_addr), 64'd0);
    chk("midrst_last",  64'(o_last), 64'd0);
    chk("midrst_data_zero", 64'(o_data != '0), 64'd0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    wr_frame(8);
    push_frame(8);
    drain(1, 200, 1'b0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ln_result_collector.md
Name: ln_result_collector

Overview:
- Sits at the receiving end of the LayerNorm stage-4 result interface: valid + 6-bit tag + 1024-bit flat data (64 lanes x 16 bit, Q10).
- That interface has no backpressure, so every beat is captured, in any order, into one half of a ping-pong frame buffer. The write location comes from the tag: bank in bits [5:4], cycle in bits [3:0].
- Once all 64 tags of a frame have arrived, the frame is streamed out in ascending tag order on a valid/ready interface toward writeback.
- The other buffer half keeps absorbing the next frame while the current one drains.

Parameters:
- DATA_W, 1024, width of one result beat (64 lanes x 16 bit).
- ADDR_W, 6, tag width; DEPTH = 2**ADDR_W = 64 beats per frame.
- NBUF, 2, number of frame buffers (ping-pong); only 2 is supported.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_res_valid  in  1  result beat strobe; no ready exists, so the beat must be taken or flagged.
- i_res_addr  in  ADDR_W  beat tag {bank[1:0], cycle[3:0]}.
- i_res_data_flat  in  DATA_W  beat payload.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accept.
- o_data  out  DATA_W  output payload.
- o_addr  out  ADDR_W  tag of the output beat.
- o_last  out  1  high on the beat with tag DEPTH-1.
- o_frame_done  out  1  one-cycle pulse on the edge a frame's last beat is accepted downstream.
- o_overflow  out  1  sticky: a beat was dropped because no buffer was free.
- o_dup_err  out  1  sticky: a tag was repeated within one frame.
- i_clear_err  in  1  synchronous clear of both sticky flags (set wins over clear in the same cycle).

Behaviour:
- Reset:
  - All outputs are 0.
  - Both buffers are empty; all 64-bit received bitmaps are cleared.
  - Write and read selectors point to buffer 0; read FSM is in IDLE.
  - Asserting reset mid-frame discards all partial and complete frames.
- Write side, sampled each edge with i_res_valid=1:
  - If full[w_sel]=0: store data at mem[w_sel][i_res_addr] and set bit i_res_addr of bitmap[w_sel].
  - If that bit was already set: overwrite the data and set o_dup_err. The bitmap is unchanged.
  - If the bitmap becomes all ones on this edge: set full[w_sel], clear bitmap[w_sel], toggle w_sel.
  - If full[w_sel]=1: drop the beat and set o_overflow.
  - full is sampled before the edge, so a beat arriving in the same cycle as that buffer's release is dropped.
- Read FSM:
  - IDLE: when full[r_sel]=1, issue a synchronous read of tag 0 and go to STREAM. o_valid rises exactly 2 edges after full[r_sel] is seen set.
  - STREAM: tags are presented in order 0..63.
    - With i_ready held high, one beat per cycle with no bubbles.
    - While o_valid=1 and i_ready=0, o_data, o_addr and o_last hold stable. The one-entry prefetch skid must not lose or duplicate a beat.
  - When the handshake with o_last=1 completes:
    - Clear full[r_sel], toggle r_sel, pulse o_frame_done, drop o_valid, return to IDLE.
    - If the other buffer is already full, its tag 0 appears exactly 2 edges later.
- A write and a drain run concurrently on different buffers. w_sel never equals r_sel while r_sel is full, except in the both-full overflow case.
- Data is passed through untouched: no arithmetic and no reordering within a beat.
- Tag-to-lane layout is preserved: o_data[16k+:16] = lane k.

Test Plan:
- In-order frame: 64 beats with tags 0..63, data = tag replicated in every lane, i_ready=1. Expect o_valid 2 cycles after the tag-63 write, then 64 consecutive beats with o_addr=0..63, o_last only on 63, one o_frame_done pulse.
- Scrambled order: tags in order bank 3..0, cycle 15..0. Expect output still ascending 0..63 with correct payloads, and no error flags.
- Backpressure: i_ready toggled 1,0,0,1 repeating during drain. Expect every beat to appear exactly once, with payload stable during stalls.
- Ping-pong overflow: frame A complete, i_ready=0, frame B fully written, then 1 extra beat. Expect o_overflow=1, the extra beat absent from output, and frames A then B delivered intact once i_ready=1.
- Duplicate tag: tag 5 sent twice (payloads 0xAAAA.., 0xBBBB..), then the remaining 63 tags. Expect o_dup_err=1, output tag 5 = 0xBBBB.., 64 beats out. i_clear_err then clears the flag.
- Reset mid-drain: i_rst_n low while o_addr=20. Expect all outputs 0 immediately. A fresh 64-beat frame afterwards outputs normally, starting at tag 0.
